bbq_lane_scroller: RTL and testbench

Note-lane engine for Barbeque Hero, directly downstream of the 3-value lane counter. It keeps one pending note, inserted into the lane the counter selects, and scrolls three lanes of notes toward the hit row at a fixed step rate. It detects player button presses against the hit row and keeps score and miss counts. Its `step` pulse is the enable for the lane counter, so lane selection advances once per scroll.

---
 rtl/bbq_lane_scroller.sv | 85 ++++++++
 tb/tb_bbq_lane_scroller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bbq_lane_scroller.sv
// Note-lane engine: holds one pending note, scrolls three lanes toward the hit
// row at a fixed step rate, and scores button presses and misses against row 0.
module bbq_lane_scroller #(
  parameter int ROWS     = 8,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spawn,
  input  logic [1:0]        lane_sel,
  input  logic [2:0]        hit,
  output logic              step,
  output logic [3*ROWS-1:0] grid,
  output logic [7:0]        score,
  output logic [7:0]        miss_count
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]     div;
  logic [2:0]        hit_q;
  logic              pend_valid;
  logic [1:0]        pend_lane;
  logic [2:0]        press;
  logic [2:0]        hit_now;
  logic [2:0]        missed;
  logic [3*ROWS-1:0] grid_next;
  logic [1:0]        hit_cnt;
  logic [1:0]        miss_cnt;
  logic [8:0]        score_sum;
  logic [8:0]        miss_sum;

  assign step  = (div == DIV_LAST);
  assign press = hit & ~hit_q;

  // Presses are judged against the pre-shift row 0, so a note hit in the step
  // cycle is cleared before it could be counted as a miss.
  always_comb begin
    grid_next = grid;
    hit_now   = '0;
    missed    = '0;
    for (int l = 0; l < 3; l++) begin
      hit_now[l]          = press[l] & grid[l*ROWS];
      missed[l]           = step & grid[l*ROWS] & ~press[l];
      grid_next[l*ROWS]   = grid[l*ROWS] & ~press[l];
      if (step) begin
        for (int r = 0; r < ROWS - 1; r++) begin
          grid_next[l*ROWS + r] = grid[l*ROWS + r + 1];
        end
        grid_next[l*ROWS + ROWS - 1] = pend_valid && (pend_lane == 2'(l));
      end
    end
  end

  assign hit_cnt   = {1'b0, hit_now[0]} + {1'b0, hit_now[1]} + {1'b0, hit_now[2]};
  assign miss_cnt  = {1'b0, missed[0]} + {1'b0, missed[1]} + {1'b0, missed[2]};
  assign score_sum = {1'b0, score} + {7'b0, hit_cnt};
  assign miss_sum  = {1'b0, miss_count} + {7'b0, miss_cnt};

  // A spawn in the step cycle outranks the clear so it lands on the next step.
  always_ff @(posedge clock) begin
    hit_q <= hit;
    if (reset) begin
      div        <= '0;
      grid       <= '0;
      score      <= '0;
      miss_count <= '0;
      pend_valid <= 1'b0;
      pend_lane  <= '0;
    end else begin
      div        <= step ? '0 : div + DW'(1);
      grid       <= grid_next;
      score      <= score_sum[8] ? 8'hFF : score_sum[7:0];
      miss_count <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
      if (spawn && lane_sel != 2'd3) begin
        pend_valid <= 1'b1;
        pend_lane  <= lane_sel;
      end else if (step) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bbq_lane_scroller.sv
// Directed bench for bbq_lane_scroller with a lane/row array model checked every cycle.
module tb_bbq_lane_scroller;

  localparam int ROWS     = 4;
  localparam int TICK_DIV = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              spawn = 1'b0;
  logic [1:0]        lane_sel = 2'd0;
  logic [2:0]        hit = 3'b000;
  logic              step;
  logic [3*ROWS-1:0] grid;
  logic [7:0]        score;
  logic [7:0]        miss_count;

  int tests  = 0;
  int failed = 0;

  bbq_lane_scroller #(.ROWS(ROWS), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .spawn(spawn), .lane_sel(lane_sel), .hit(hit),
    .step(step), .grid(grid), .score(score), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Model: notes as a lane x row array, step timing from a cycle count since reset.
  bit       m_grid [3][ROWS];
  int       m_pend = -1;
  int       m_score = 0;
  int       m_miss = 0;
  int       m_cyc = 0;
  bit [2:0] m_hq = '0;
  bit       model_valid = 0;

  function automatic int model_grid();
    int g = 0;
    for (int l = 0; l < 3; l++)
      for (int r = 0; r < ROWS; r++)
        if (m_grid[l][r]) g |= (1 << (l*ROWS + r));
    return g;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < 3; l++)
        for (int r = 0; r < ROWS; r++) m_grid[l][r] = 0;
      m_pend = -1; m_score = 0; m_miss = 0; m_cyc = 0;
      m_hq = hit; model_valid = 1;
    end else begin
      bit st;
      st = (m_cyc % TICK_DIV) == TICK_DIV - 1;
      for (int l = 0; l < 3; l++)
        if (hit[l] && !m_hq[l] && m_grid[l][0]) begin
          m_grid[l][0] = 0;
          if (m_score < 255) m_score++;
        end
      if (st) begin
        for (int l = 0; l < 3; l++) begin
          if (m_grid[l][0] && m_miss < 255) m_miss++;
          for (int r = 0; r < ROWS - 1; r++) m_grid[l][r] = m_grid[l][r+1];
          m_grid[l][ROWS-1] = (m_pend == l);
        end
        m_pend = -1;
      end
      if (spawn && lane_sel != 2'd3) m_pend = int'(lane_sel);
      m_hq = hit;
      m_cyc++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("model_step", int'(step), int'((m_cyc % TICK_DIV) == TICK_DIV - 1));
      checkOutput("model_grid", int'(grid), model_grid());
      checkOutput("model_score", int'(score), m_score);
      checkOutput("model_miss", int'(miss_count), m_miss);
    end
  end

  task automatic applyStimulus(input logic r, input logic sp, input logic [1:0] ls,
                               input logic [2:0] h);
    reset = r; spawn = sp; lane_sel = ls; hit = h;
    @(negedge clock);
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1; spawn = 1'b0; hit = 3'b000;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitStepCycle();
    int n = 0;
    while ((m_cyc % TICK_DIV) != TICK_DIV - 1) begin
      @(negedge clock);
      n++;
      if (n > 4 * TICK_DIV) begin
        checkOutput("step_timeout", n, 0);
        return;
      end
    end
  endtask

  task automatic doSteps(input int n);
    repeat (n) begin
      waitStepCycle();
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and step rate
    applyReset(3);
    checkOutput("reset_grid", int'(grid), 0);
    checkOutput("reset_score", int'(score), 0);
    checkOutput("reset_miss", int'(miss_count), 0);
    for (int i = 1; i <= 12; i++) begin
      checkOutput("step_rate", int'(step), int'(i % 4 == 0));
      @(negedge clock);
    end

    // Spawn and miss
    applyStimulus(1'b0, 1'b1, 2'd1, 3'b000);
    spawn = 1'b0;
    doSteps(1);
    checkOutput("spawn_top", int'(grid), 12'h080);
    doSteps(3);
    checkOutput("spawn_row0", int'(grid), 12'h010);
    doSteps(1);
    checkOutput("miss_grid", int'(grid), 0);
    checkOutput("miss_count1", int'(miss_count), 1);
    checkOutput("miss_score", int'(score), 0);

    // Hit and held button
    applyReset(2);
    applyStimulus(1'b0, 1'b1, 2'd1, 3'b000);
    spawn = 1'b0;
    doSteps(4);
    checkOutput("held_pre", int'(grid), 12'h010);
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b010);
    checkOutput("held_score", int'(score), 1);
    checkOutput("held_grid", int'(grid), 0);
    repeat (9) @(negedge clock);
    checkOutput("held_score_hold", int'(score), 1);
    checkOutput("held_miss", int'(miss_count), 0);
    hit = 3'b000;

    // Press coinciding with step
    applyReset(2);
    applyStimulus(1'b0, 1'b1, 2'd2, 3'b000);
    spawn = 1'b0;
    doSteps(4);
    checkOutput("coinc_pre", int'(grid), 12'h100);
    waitStepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b100);
    hit = 3'b000;
    checkOutput("coinc_score", int'(score), 1);
    checkOutput("coinc_miss", int'(miss_count), 0);
    checkOutput("coinc_lane2", int'(grid[11:8]), 0);

    // Spawn filtering
    applyReset(2);
    applyStimulus(1'b0, 1'b1, 2'd3, 3'b000);
    spawn = 1'b0;
    doSteps(1);
    checkOutput("filter_lane3", int'(grid), 0);
    applyStimulus(1'b0, 1'b1, 2'd0, 3'b000);
    applyStimulus(1'b0, 1'b1, 2'd2, 3'b000);
    spawn = 1'b0;
    doSteps(1);
    checkOutput("filter_last_wins", int'(grid), 12'h800);
    waitStepCycle();
    applyStimulus(1'b0, 1'b1, 2'd1, 3'b000);
    spawn = 1'b0;
    checkOutput("filter_step_spawn_late", int'(grid), 12'h400);
    doSteps(1);
    checkOutput("filter_step_spawn_next", int'(grid), 12'h280);

    // Miss saturation: a note enters lane 0 on every step
    applyReset(2);
    spawn = 1'b1; lane_sel = 2'd0;
    doSteps(200);
    checkOutput("sat_miss_196", int'(miss_count), 196);
    doSteps(64);
    checkOutput("sat_miss_255", int'(miss_count), 255);
    spawn = 1'b0;

    // Score saturation: press once per step period
    applyReset(2);
    spawn = 1'b1; lane_sel = 2'd0;
    doSteps(4);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 3'b001);
      hit = 3'b000;
      if (i == 249) checkOutput("sat_score_250", int'(score), 250);
      doSteps(1);
    end
    checkOutput("sat_score_255", int'(score), 255);
    checkOutput("sat_score_miss", int'(miss_count), 0);
    spawn = 1'b0;

    // Reset overrides a pending press
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b001);
    checkOutput("reset_mid_score", int'(score), 0);
    checkOutput("reset_mid_grid", int'(grid), 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b001);
    hit = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
